// File: rtl/count99_down_timer.sv
// Mod-100 down timer with load/start/pause and BCD digit outputs.
// Optional COUNT99_AUTORELOAD_EN: reload from R instead of stopping in DONE.
module count99_down_timer #(
  parameter int MAXV = 99,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  output logic [W-1:0] out,
  output logic [3:0]   tens,
  output logic [3:0]   ones,
  output logic         running,
  output logic         done,
  output logic         expired
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t       state, state_n;
  logic [W-1:0] rld, rld_n;
  logic [W-1:0] q_n;
  logic         exp_n;
  logic [W-1:0] clamp;

  assign clamp = (load_val > W'(MAXV)) ? W'(MAXV) : load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      out     <= '0;
      rld     <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      out     <= q_n;
      rld     <= rld_n;
      expired <= exp_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = out;
    rld_n   = rld;
    exp_n   = 1'b0;
    if (load) begin
      q_n     = clamp;
      rld_n   = clamp;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && out != '0)
            state_n = RUN;
        end
        RUN: begin
          // pause wins over enable and start in the same cycle
          if (pause) begin
            state_n = PAUSED;
          end else if (enable) begin
            if (out > W'(1)) begin
              q_n = out - W'(1);
            end else begin
              exp_n = 1'b1;
`ifdef COUNT99_AUTORELOAD_EN
              q_n = rld;
`else
              q_n     = '0;
              state_n = DONE;
`endif
            end
          end
        end
        PAUSED: begin
          if (start && !pause)
            state_n = RUN;
        end
        DONE: begin
          q_n = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign tens    = 4'(out / W'(10));
  assign ones    = 4'(out % W'(10));
  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_count99_down_timer.sv
// Self-checking bench for count99_down_timer: directed scenarios plus
// random stimulus against a behavioural model.
module tb_count99_down_timer;

  logic       clk = 1'b0;
  logic       rst, enable, load, start, pause;
  logic [7:0] load_val;
  logic [7:0] out;
  logic [3:0] tens, ones;
  logic       running, done, expired;
  logic [18:0] got;

  int errors = 0;
  int checks = 0;

  // model: mode 0=idle 1=run 2=paused 3=done
  int m_q, m_r, m_mode;
  bit m_x;

  count99_down_timer dut (
    .clk(clk), .rst(rst), .enable(enable),
    .load(load), .load_val(load_val),
    .start(start), .pause(pause),
    .out(out), .tens(tens), .ones(ones),
    .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  assign got = {out, tens, ones, running, done, expired};

  function automatic logic [18:0] ev(int q, bit r, bit d, bit x);
    return {8'(q), 4'(q / 10), 4'(q % 10), r, d, x};
  endfunction

  task automatic model(input bit rs, ld, input int lv,
                       input bit st, ps, en);
    if (rs) begin
      m_q = 0; m_r = 0; m_mode = 0; m_x = 0;
    end else if (ld) begin
      m_q = (lv > 99) ? 99 : lv;
      m_r = m_q; m_mode = 0; m_x = 0;
    end else begin
      m_x = 0;
      case (m_mode)
        0: if (st && m_q != 0) m_mode = 1;
        1: if (ps) m_mode = 2;
           else if (en) begin
             if (m_q > 1) m_q = m_q - 1;
             else begin
               m_x = 1;
`ifdef COUNT99_AUTORELOAD_EN
               m_q = m_r;
`else
               m_q = 0; m_mode = 3;
`endif
             end
           end
        2: if (st && !ps) m_mode = 1;
        default: ;
      endcase
    end
  endtask

  task automatic drive(input bit rs, ld, input int lv,
                       input bit st, ps, en);
    rst = rs; load = ld; load_val = 8'(lv);
    start = st; pause = ps; enable = en;
    model(rs, ld, lv, st, ps, en);
    @(posedge clk);
    #1;
    rst = 0; load = 0; start = 0; pause = 0; enable = 0;
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (got !== ev(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", got, ev(0, 0, 0, 0));
    end
    drive(0, 1, 250, 0, 0, 0);
    checks++;
    if (got !== ev(99, 0, 0, 0)) begin
      errors++;
      $display("FAIL clamp250 got=%h exp=%h", got, ev(99, 0, 0, 0));
    end
  endtask

  task automatic test_countdown;
`ifdef COUNT99_AUTORELOAD_EN
    int seq[6] = '{2, 1, 3, 2, 1, 3};
    drive(0, 1, 3, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (got !== ev(3, 1, 0, 0)) begin
      errors++;
      $display("FAIL ar_start got=%h exp=%h", got, ev(3, 1, 0, 0));
    end
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      checks++;
      if (got !== ev(seq[k], 1, 0, seq[k] == 3)) begin
        errors++;
        $display("FAIL ar_seq%0d got=%h exp=%h", k, got,
                 ev(seq[k], 1, 0, seq[k] == 3));
      end
    end
`else
    drive(0, 1, 5, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (got !== ev(5, 1, 0, 0)) begin
      errors++;
      $display("FAIL cd_start got=%h exp=%h", got, ev(5, 1, 0, 0));
    end
    for (int i = 4; i >= 0; i--) begin
      drive(0, 0, 0, 0, 0, 1);
      checks++;
      if (got !== ev(i, i != 0, i == 0, i == 0)) begin
        errors++;
        $display("FAIL cd_out%0d got=%h exp=%h", i, got,
                 ev(i, i != 0, i == 0, i == 0));
      end
    end
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (got !== ev(0, 0, 1, 0)) begin
      errors++;
      $display("FAIL cd_hold got=%h exp=%h", got, ev(0, 0, 1, 0));
    end
    drive(0, 0, 0, 1, 1, 1);
    checks++;
    if (got !== ev(0, 0, 1, 0)) begin
      errors++;
      $display("FAIL done_start got=%h exp=%h", got, ev(0, 0, 1, 0));
    end
`endif
  endtask

  task automatic test_pause;
    drive(0, 1, 10, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (got !== ev(7, 1, 0, 0)) begin
      errors++;
      $display("FAIL p_run7 got=%h exp=%h", got, ev(7, 1, 0, 0));
    end
    repeat (4) drive(0, 0, 0, 0, 1, 1);
    checks++;
    if (got !== ev(7, 0, 0, 0)) begin
      errors++;
      $display("FAIL p_hold got=%h exp=%h", got, ev(7, 0, 0, 0));
    end
    drive(0, 0, 0, 1, 0, 1);
    checks++;
    if (got !== ev(7, 1, 0, 0)) begin
      errors++;
      $display("FAIL p_resume got=%h exp=%h", got, ev(7, 1, 0, 0));
    end
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (got !== ev(6, 1, 0, 0)) begin
      errors++;
      $display("FAIL p_dec got=%h exp=%h", got, ev(6, 1, 0, 0));
    end
  endtask

  task automatic test_zero_load;
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1);
    checks++;
    if (got !== ev(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL zero_start got=%h exp=%h", got, ev(0, 0, 0, 0));
    end
  endtask

  task automatic test_override;
    drive(0, 1, 50, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    repeat (8) drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (got !== ev(42, 1, 0, 0)) begin
      errors++;
      $display("FAIL ov_42 got=%h exp=%h", got, ev(42, 1, 0, 0));
    end
    drive(1, 1, 77, 1, 0, 1);
    checks++;
    if (got !== ev(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL ov_rst got=%h exp=%h", got, ev(0, 0, 0, 0));
    end
    drive(0, 1, 20, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 23, 1, 0, 1);
    checks++;
    if (got !== ev(23, 0, 0, 0)) begin
      errors++;
      $display("FAIL ov_load got=%h exp=%h", got, ev(23, 0, 0, 0));
    end
  endtask

  task automatic test_random;
    logic [18:0] e;
    bit rs, ld, st, ps, en;
    int lv;
    drive(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      rs = ($urandom_range(0, 63) == 0);
      ld = ($urandom_range(0, 15) == 0);
      lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                       : $urandom_range(0, 8);
      st = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 7) == 0);
      en = $urandom_range(0, 1) == 1;
      drive(rs, ld, lv, st, ps, en);
      e = ev(m_q, m_mode == 1, m_mode == 3, m_x);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rand%0d got=%h exp=%h", n, got, e);
      end
    end
  endtask

  initial begin
    rst = 1; load = 0; load_val = 0;
    start = 0; pause = 0; enable = 0;
    m_q = 0; m_r = 0; m_mode = 0; m_x = 0;
    @(posedge clk);
    #1;
    test_reset;
    test_countdown;
    test_pause;
    test_zero_load;
    test_override;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count99_down_timer.md
Name: count99_down_timer

Overview:
- Mod-100 down-counting timer; complements the team's 0–99 up counter.
- Loads a start value, decrements once per `enable` strobe while running, and stops at 0 with a done indication.
- Sits beside the up counter in the lab display datapath. Its count and BCD digits drive the seven-segment decoders.

Parameters:
- MAXV, 99, highest legal count; larger load values clamp to MAXV.
- W, 8, count width in bits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset, sampled on posedge clk.
- enable  input  1  count strobe; one decrement per cycle it is high while running.
- load  input  1  load strobe; captures load_val.
- load_val  input  W  value to load (0..255 accepted, clamped).
- start  input  1  start or resume request.
- pause  input  1  pause request.
- out  output  W  current count, registered.
- tens  output  4  BCD tens digit of out, combinational (out / 10).
- ones  output  4  BCD ones digit of out, combinational (out % 10).
- running  output  1  high when state is RUN.
- done  output  1  high when state is DONE.
- expired  output  1  one-cycle pulse when count reaches 0 from a run.

Behaviour:
- States: IDLE, RUN, PAUSED, DONE. Registered state; out is the count register Q.
- Reset (rst=1 at posedge):
  - Q=0, reload register R=0, state=IDLE, expired=0.
  - Therefore out=0, tens=0, ones=0, running=0, done=0.
  - rst overrides every other input, including mid-run.
- Load (highest priority after rst, valid in any state):
  - Q <= min(load_val, MAXV); R <= same value; state <= IDLE; expired <= 0.
  - start, pause and enable are ignored in the cycle load is high.
- IDLE:
  - start=1 and Q!=0 -> RUN.
  - start=1 and Q==0 -> stay IDLE; no expired pulse.
  - pause is ignored.
- RUN:
  - pause=1 -> PAUSED; no decrement that cycle, even if enable=1.
  - pause and start both high -> PAUSED.
  - Else enable=1 and Q>1 -> Q <= Q-1.
  - Else enable=1 and Q==1 -> Q <= 0, state <= DONE, expired <= 1 for exactly the next cycle.
  - enable=0 -> hold.
- PAUSED:
  - start=1 and pause=0 -> RUN; no decrement on the resume edge.
  - Otherwise hold Q.
- DONE:
  - Q holds 0.
  - start and pause are ignored.
  - Leave only via load or rst.
- Outputs:
  - expired is registered: high in the first cycle state==DONE, low thereafter.
  - Q never exceeds MAXV and never underflows below 0; no wrap from 0 to 99 in the base build.
  - tens/ones are valid for all Q in 0..99.

Optional Feature:
- Macro: COUNT99_AUTORELOAD_EN.
- Defined: on RUN with enable=1 and Q==1:
  - Q <= R, state stays RUN, expired pulses high for one cycle.
  - DONE is unreachable and done stays 0.
  - If R==1, expired pulses on every enable strobe.
  - Load still updates R and returns to IDLE.
- Not defined: behaviour exactly as above; the count stops in DONE.

Test Plan:
- Reset → out=0, tens=0, ones=0, running=0, done=0, expired=0. Then load_val=250, load=1 → out=99, tens=9, ones=9, state IDLE.
- Load 5, start, enable held high → out 5,4,3,2,1,0 on successive cycles. done=1 from the cycle out=0; expired=1 in that cycle only; further enable leaves out=0.
- Load 10, start, 3 enables → out=7. Pause with enable=1 for 4 cycles → out stays 7. Start with pause=0 → running=1, then next enable → 6.
- Load 0, start → state stays IDLE, running=0, no expired pulse. Start while in DONE → no change.
- rst=1 mid-run at out=42 → next cycle out=0, IDLE. Load 23 while running at out=15 → out=23, running=0, tens=2, ones=3.
- With COUNT99_AUTORELOAD_EN: load 3, start, continuous enable → out 3,2,1,3,2,1,…. expired pulses in each cycle out returns to 3; done never asserts.
